// File: rtl/banked_regfile_pkg.sv
// Shared constants and types for the banked register file.
// Default geometry, endian-mode encoding and the PC slot location live here.
package banked_regfile_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int WORD_DEF  = 4;
    localparam int FULLW_DEF = WIDTH_DEF * WORD_DEF;
    localparam int NREGS_DEF = 16;
    localparam int ADDRW_DEF = 4;

    typedef enum logic {
        LITTLE = 1'b0,
        BIG    = 1'b1
    } endian_e;

    // The auto-incrementing PC always occupies the highest register index.
    function automatic int pc_index(input int nregs);
        return nregs - 1;
    endfunction

endpackage

// File: rtl/banked_regfile_if.sv
// Decode/writeback-side bus of the banked register file.
// The datapath drives it through the master modport; the register file uses the slave modport.
interface banked_regfile_if #(
    parameter int WIDTH = banked_regfile_pkg::WIDTH_DEF,
    parameter int WORD  = banked_regfile_pkg::WORD_DEF,
    parameter int ADDRW = banked_regfile_pkg::ADDRW_DEF
);

    localparam int FULLW = WIDTH * WORD;

    logic             big_endian;
    logic             we;
    logic [ADDRW-1:0] waddr;
    logic [FULLW-1:0] wdata;
    logic [WORD-1:0]  wbe;
    logic             pc_inc;
    logic [ADDRW-1:0] ra0;
    logic [ADDRW-1:0] ra1;
    logic [FULLW-1:0] rd0;
    logic [FULLW-1:0] rd1;

    modport master (
        output big_endian, we, waddr, wdata, wbe, pc_inc, ra0, ra1,
        input  rd0, rd1
    );

    modport slave (
        input  big_endian, we, waddr, wdata, wbe, pc_inc, ra0, ra1,
        output rd0, rd1
    );

endinterface

// File: rtl/banked_regfile_byte_lane_map.sv
// Combinational bus <-> storage byte reorder.
// Big-endian mode is a pure lane reversal, so the same block serves both directions.
module byte_lane_map
    import banked_regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int WORD  = WORD_DEF
) (
    input  logic                  big_endian,
    input  logic [WIDTH*WORD-1:0] data_in,
    output logic [WIDTH*WORD-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        if (big_endian == BIG) begin
            for (int i = 0; i < WORD; i++) begin
                data_out[(WORD-1-i)*WIDTH +: WIDTH] = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/banked_regfile.sv
// Byte-addressed register file: two registered read ports with write-first bypass,
// one byte-enabled write port, runtime endian mapping and an optional auto-incrementing PC.
module banked_regfile
    import banked_regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int WORD  = WORD_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int ADDRW = ADDRW_DEF,
    parameter bit PC_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    banked_regfile_if.slave bus
);

    localparam int               FULLW   = WIDTH * WORD;
    localparam int               PC_IDX  = pc_index(NREGS);
    localparam logic [ADDRW-1:0] PC_ADDR = ADDRW'(PC_IDX);

    // Row storage: element i of a row is storage byte i.
    typedef logic [WORD-1:0][WIDTH-1:0] row_t;

    row_t mem [NREGS];

    logic [FULLW-1:0] wr_flat;
    row_t             wr_row;
    row_t             merged_row;
    row_t             pc_row;
    row_t             pc_inc_row;
    logic [FULLW-1:0] pc_logical;
    logic [FULLW-1:0] pc_sum;
    logic             write_hit;
    logic             pc_write_hit;
    logic             pc_step;

    logic [1:0][ADDRW-1:0] ra_sel;
    logic [1:0][FULLW-1:0] rd_bus_next;
    logic [FULLW-1:0]      rd0_q;
    logic [FULLW-1:0]      rd1_q;

    byte_lane_map #(
        .WIDTH(WIDTH),
        .WORD (WORD)
    ) u_write_map (
        .big_endian(bus.big_endian),
        .data_in   (bus.wdata),
        .data_out  (wr_flat)
    );

    assign wr_row = wr_flat;

    // A write with no byte enables is a no-op, so it must neither claim the PC nor the bypass.
    always_comb begin
        write_hit    = bus.we && (bus.wbe != '0);
        pc_write_hit = write_hit && (bus.waddr == PC_ADDR);
        pc_step      = PC_EN && bus.pc_inc && !pc_write_hit;

        merged_row = mem[bus.waddr];
        for (int i = 0; i < WORD; i++) begin
            if (bus.wbe[i]) begin
                merged_row[i] = wr_row[i];
            end
        end
    end

    // PC arithmetic runs on the logical value, where storage byte 0 is the most significant.
    always_comb begin
        pc_row     = mem[PC_IDX];
        pc_logical = '0;
        for (int i = 0; i < WORD; i++) begin
            pc_logical[(WORD-1-i)*WIDTH +: WIDTH] = pc_row[i];
        end

        pc_sum     = pc_logical + FULLW'(WORD);
        pc_inc_row = '0;
        for (int i = 0; i < WORD; i++) begin
            pc_inc_row[i] = pc_sum[(WORD-1-i)*WIDTH +: WIDTH];
        end
    end

    assign ra_sel = {bus.ra1, bus.ra0};

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_read
            row_t next_row;

            // Each port sees the register's next state, so same-edge writes and increments bypass.
            always_comb begin
                next_row = mem[ra_sel[p]];
                if (pc_step && (ra_sel[p] == PC_ADDR)) begin
                    next_row = pc_inc_row;
                end
                if (write_hit && (ra_sel[p] == bus.waddr)) begin
                    next_row = merged_row;
                end
            end

            byte_lane_map #(
                .WIDTH(WIDTH),
                .WORD (WORD)
            ) u_read_map (
                .big_endian(bus.big_endian),
                .data_in   (next_row),
                .data_out  (rd_bus_next[p])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            if (write_hit) begin
                mem[bus.waddr] <= merged_row;
            end
            if (pc_step) begin
                mem[PC_IDX] <= pc_inc_row;
            end
            rd0_q <= rd_bus_next[0];
            rd1_q <= rd_bus_next[1];
        end
    end

    assign bus.rd0 = rd0_q;
    assign bus.rd1 = rd1_q;

endmodule
